// File: rtl/cpu_bus_debug_monitor.sv
// rtl/cpu_bus_debug_monitor.sv - passive CPU PC/bus observer with event counters, trace strobe and hang detect
module cpu_bus_debug_monitor #(
    parameter int HANG_CYCLES = 1000000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_PC,
    input  logic [31:0] i_instruction,
    input  logic [31:0] i_mem_address,
    input  logic [31:0] i_mem_data,
    input  logic        i_mem_DV,
    input  logic        i_mem_write,
    input  logic        i_enable_debug,
    input  logic [1:0]  i_debug_verbosity,
    output logic [31:0] o_cycle_count,
    output logic [31:0] o_pc_change_count,
    output logic [31:0] o_mem_read_count,
    output logic [31:0] o_mem_write_count,
    output logic [31:0] o_last_pc,
    output logic [31:0] o_stall_cycles,
    output logic        o_hang,
    output logic        o_trace_valid,
    output logic [1:0]  o_trace_kind,
    output logic [31:0] o_trace_addr,
    output logic [31:0] o_trace_data,
    output logic [6:0]  o_trace_opcode
);

    localparam logic [31:0] HANG_LIMIT = 32'(HANG_CYCLES);
    localparam logic [31:0] SAT_MAX    = 32'hFFFF_FFFF;

    localparam logic [1:0] KIND_PC    = 2'd0;
    localparam logic [1:0] KIND_READ  = 2'd2;
    localparam logic [1:0] KIND_WRITE = 2'd3;

    logic        primed;
    logic [31:0] prev_pc;

    logic        pc_change;
    logic        mem_read;
    logic        mem_write;
    logic        trace_pc;
    logic        trace_mem;
    logic        trace_evt;
    logic [1:0]  trace_kind_nxt;
    logic [31:0] trace_addr_nxt;
    logic [31:0] trace_data_nxt;
    logic [6:0]  trace_opcode_nxt;
    logic [31:0] stall_inc;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == SAT_MAX) ? v : v + 32'd1;
    endfunction

    always_comb begin
        pc_change        = primed && (i_PC != prev_pc);
        mem_read         = i_mem_DV && !i_mem_write;
        mem_write        = i_mem_DV &&  i_mem_write;
        trace_pc         = i_enable_debug && (i_debug_verbosity != 2'd0) && pc_change;
        trace_mem        = i_enable_debug && (i_debug_verbosity >= 2'd2) && i_mem_DV;
        trace_evt        = trace_pc || trace_mem;
        stall_inc        = sat_inc(o_stall_cycles);

        // A same-cycle bus access wins the single trace slot over the PC change.
        trace_kind_nxt   = KIND_PC;
        trace_addr_nxt   = i_PC;
        trace_data_nxt   = i_instruction;
        if (trace_mem) begin
            trace_kind_nxt = i_mem_write ? KIND_WRITE : KIND_READ;
            trace_addr_nxt = i_mem_address;
            trace_data_nxt = i_mem_data;
        end
        trace_opcode_nxt = (i_debug_verbosity == 2'd3) ? i_instruction[6:0] : 7'd0;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            primed            <= 1'b0;
            prev_pc           <= '0;
            o_cycle_count     <= '0;
            o_pc_change_count <= '0;
            o_mem_read_count  <= '0;
            o_mem_write_count <= '0;
            o_last_pc         <= '0;
            o_stall_cycles    <= '0;
            o_hang            <= 1'b0;
        end else begin
            o_cycle_count <= sat_inc(o_cycle_count);

            if (!primed) begin
                primed    <= 1'b1;
                prev_pc   <= i_PC;
                o_last_pc <= i_PC;
            end else if (pc_change) begin
                o_pc_change_count <= sat_inc(o_pc_change_count);
                prev_pc           <= i_PC;
                o_last_pc         <= i_PC;
                o_stall_cycles    <= '0;
            end else begin
                o_stall_cycles <= stall_inc;
                if (stall_inc >= HANG_LIMIT) begin
                    o_hang <= 1'b1;
                end
            end

            if (mem_read) begin
                o_mem_read_count <= sat_inc(o_mem_read_count);
            end
            if (mem_write) begin
                o_mem_write_count <= sat_inc(o_mem_write_count);
            end
        end
    end

    // Trace fields are sticky; only the strobe drops back between events.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_trace_valid  <= 1'b0;
            o_trace_kind   <= '0;
            o_trace_addr   <= '0;
            o_trace_data   <= '0;
            o_trace_opcode <= '0;
        end else begin
            o_trace_valid <= trace_evt;
            if (trace_evt) begin
                o_trace_kind   <= trace_kind_nxt;
                o_trace_addr   <= trace_addr_nxt;
                o_trace_data   <= trace_data_nxt;
                o_trace_opcode <= trace_opcode_nxt;
            end
        end
    end

`ifdef SIMULATION
    always @(posedge i_clk) begin
        if (!i_reset && trace_evt) begin
            if (i_debug_verbosity == 2'd3)
                $display("%0t trace kind=%0d addr=%h data=%h opcode=%h",
                         $time, trace_kind_nxt, trace_addr_nxt, trace_data_nxt, trace_opcode_nxt);
            else
                $display("%0t trace kind=%0d addr=%h data=%h",
                         $time, trace_kind_nxt, trace_addr_nxt, trace_data_nxt);
        end
    end
`endif

endmodule

// File: tb/tb_cpu_bus_debug_monitor.sv
// tb/tb_cpu_bus_debug_monitor.sv - directed self-checking bench for cpu_bus_debug_monitor
module tb_cpu_bus_debug_monitor;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [31:0] i_PC;
    logic [31:0] i_instruction;
    logic [31:0] i_mem_address;
    logic [31:0] i_mem_data;
    logic        i_mem_DV;
    logic        i_mem_write;
    logic        i_enable_debug;
    logic [1:0]  i_debug_verbosity;
    logic [31:0] o_cycle_count;
    logic [31:0] o_pc_change_count;
    logic [31:0] o_mem_read_count;
    logic [31:0] o_mem_write_count;
    logic [31:0] o_last_pc;
    logic [31:0] o_stall_cycles;
    logic        o_hang;
    logic        o_trace_valid;
    logic [1:0]  o_trace_kind;
    logic [31:0] o_trace_addr;
    logic [31:0] o_trace_data;
    logic [6:0]  o_trace_opcode;

    int checks = 0;
    int errors = 0;
    int exp_cyc = 0;

    always #5 i_clk = ~i_clk;

    cpu_bus_debug_monitor #(.HANG_CYCLES(8)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_PC(i_PC), .i_instruction(i_instruction),
        .i_mem_address(i_mem_address), .i_mem_data(i_mem_data), .i_mem_DV(i_mem_DV),
        .i_mem_write(i_mem_write), .i_enable_debug(i_enable_debug),
        .i_debug_verbosity(i_debug_verbosity), .o_cycle_count(o_cycle_count),
        .o_pc_change_count(o_pc_change_count), .o_mem_read_count(o_mem_read_count),
        .o_mem_write_count(o_mem_write_count), .o_last_pc(o_last_pc),
        .o_stall_cycles(o_stall_cycles), .o_hang(o_hang), .o_trace_valid(o_trace_valid),
        .o_trace_kind(o_trace_kind), .o_trace_addr(o_trace_addr), .o_trace_data(o_trace_data),
        .o_trace_opcode(o_trace_opcode)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        if (i_reset) exp_cyc = 0;
        else exp_cyc++;
        #1;
    endtask

    initial begin
        i_reset = 1'b1; i_PC = 32'h8000_0000; i_instruction = 32'h0;
        i_mem_address = '0; i_mem_data = '0; i_mem_DV = 1'b0; i_mem_write = 1'b0;
        i_enable_debug = 1'b1; i_debug_verbosity = 2'd1;

        repeat (3) tick();
        check("rst_cycle",   o_cycle_count, 32'd0);
        check("rst_last_pc", o_last_pc, 32'd0);
        check("rst_hang",    32'(o_hang), 32'd0);
        check("rst_valid",   32'(o_trace_valid), 32'd0);
        check("rst_rdcnt",   o_mem_read_count, 32'd0);

        i_reset = 1'b0;
        tick();
        check("prime_last_pc", o_last_pc, 32'h8000_0000);
        check("prime_pcchg",   o_pc_change_count, 32'd0);
        check("prime_valid",   32'(o_trace_valid), 32'd0);
        check("prime_cycle",   o_cycle_count, 32'(exp_cyc));
        check("prime_stall",   o_stall_cycles, 32'd0);
        tick();
        check("hold_stall", o_stall_cycles, 32'd1);

        i_PC = 32'h8000_0004; i_instruction = 32'h0000_0013;
        tick();
        check("pc1_count", o_pc_change_count, 32'd1);
        check("pc1_valid", 32'(o_trace_valid), 32'd1);
        check("pc1_kind",  32'(o_trace_kind), 32'd0);
        check("pc1_addr",  o_trace_addr, 32'h8000_0004);
        check("pc1_data",  o_trace_data, 32'h0000_0013);
        check("pc1_opc",   32'(o_trace_opcode), 32'd0);
        check("pc1_stall", o_stall_cycles, 32'd0);

        i_PC = 32'h8000_0008; i_instruction = 32'h0000_006F;
        tick();
        check("pc2_count", o_pc_change_count, 32'd2);
        check("pc2_valid", 32'(o_trace_valid), 32'd1);
        check("pc2_addr",  o_trace_addr, 32'h8000_0008);
        check("pc2_data",  o_trace_data, 32'h0000_006F);
        tick();
        check("idle_valid", 32'(o_trace_valid), 32'd0);
        check("idle_hold",  o_trace_addr, 32'h8000_0008);

        i_debug_verbosity = 2'd2; i_PC = 32'h8000_000C; i_instruction = 32'h0011_2023;
        i_mem_DV = 1'b1; i_mem_write = 1'b1; i_mem_address = 32'h1000_0000; i_mem_data = 32'h41;
        tick();
        check("wr_count",  o_mem_write_count, 32'd1);
        check("wr_pcchg",  o_pc_change_count, 32'd3);
        check("wr_lastpc", o_last_pc, 32'h8000_000C);
        check("wr_valid",  32'(o_trace_valid), 32'd1);
        check("wr_kind",   32'(o_trace_kind), 32'd3);
        check("wr_addr",   o_trace_addr, 32'h1000_0000);
        check("wr_data",   o_trace_data, 32'h41);

        i_mem_DV = 1'b0; i_mem_write = 1'b0;
        i_debug_verbosity = 2'd3; i_PC = 32'h8000_0010; i_instruction = 32'h0000_0033;
        tick();
        check("v3_kind", 32'(o_trace_kind), 32'd0);
        check("v3_opc",  32'(o_trace_opcode), 32'h33);

        i_mem_DV = 1'b1; i_mem_address = 32'h2000_0000; i_mem_data = 32'h5A;
        i_debug_verbosity = 2'd0;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) begin
                i_debug_verbosity = 2'd3; i_enable_debug = 1'b0;
            end
            tick();
            check("quiet_valid", 32'(o_trace_valid), 32'd0);
        end
        check("rd_count", o_mem_read_count, 32'd5);
        check("rd_stall", o_stall_cycles, 32'd5);
        check("rd_cycle", o_cycle_count, 32'(exp_cyc));

        i_mem_DV = 1'b0;
        tick(); tick();
        check("pre_hang_stall", o_stall_cycles, 32'd7);
        check("pre_hang",       32'(o_hang), 32'd0);
        tick();
        check("hang_stall", o_stall_cycles, 32'd8);
        check("hang_rise",  32'(o_hang), 32'd1);

        i_enable_debug = 1'b1; i_debug_verbosity = 2'd1; i_PC = 32'h8000_0014;
        tick();
        check("recover_stall", o_stall_cycles, 32'd0);
        check("recover_hang",  32'(o_hang), 32'd1);
        check("recover_pcchg", o_pc_change_count, 32'd5);
        check("recover_valid", 32'(o_trace_valid), 32'd1);

        i_reset = 1'b1; i_mem_DV = 1'b1; i_mem_write = 1'b1; i_PC = 32'h8000_0018;
        tick();
        check("mid_rst_wr",    o_mem_write_count, 32'd0);
        check("mid_rst_pcchg", o_pc_change_count, 32'd0);
        check("mid_rst_hang",  32'(o_hang), 32'd0);
        check("mid_rst_cycle", o_cycle_count, 32'd0);
        check("mid_rst_valid", 32'(o_trace_valid), 32'd0);

        i_reset = 1'b0; i_mem_DV = 1'b0; i_mem_write = 1'b0;
        tick();
        check("reprime_lastpc", o_last_pc, 32'h8000_0018);
        check("reprime_cycle",  o_cycle_count, 32'd1);
        check("reprime_wr",     o_mem_write_count, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
